// File: rtl/mem_subsystem_if.sv
// Bus bundle for the core's memory block: instruction fetch, program load and
// data load/store, plus the two error flags.
interface mem_subsystem_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      Pc;
    logic [WIDTH-1:0] InstReg;
    logic             ImLoadEn;
    logic [31:0]      ImLoadAddr;
    logic [WIDTH-1:0] ImLoadData;
    logic [31:0]      Address;
    logic [WIDTH-1:0] WriteData;
    logic             MemRead;
    logic             MemWrite;
    logic [WIDTH-1:0] ReadData;
    logic             InstErr;
    logic             DataErr;

    modport master (
        output Pc, ImLoadEn, ImLoadAddr, ImLoadData,
        output Address, WriteData, MemRead, MemWrite,
        input  InstReg, ReadData, InstErr, DataErr
    );

    modport slave (
        input  Pc, ImLoadEn, ImLoadAddr, ImLoadData,
        input  Address, WriteData, MemRead, MemWrite,
        output InstReg, ReadData, InstErr, DataErr
    );
endinterface

// File: rtl/mem_subsystem.sv
// Word-organised instruction memory (registered fetch, loadable) and data
// memory (async read, sync write) for the single-cycle 32-bit core.
module mem_subsystem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic           Clk,
    input  logic           Rst_n,
    mem_subsystem_if.slave bus
);

    logic [WIDTH-1:0] r_imem [DEPTH];
    logic [WIDTH-1:0] r_dmem [DEPTH];
    logic [WIDTH-1:0] r_inst;

    logic          w_pc_ok;
    logic          w_ld_ok;
    logic          w_addr_ok;
    logic [AW-1:0] w_pc_idx;
    logic [AW-1:0] w_ld_idx;
    logic [AW-1:0] w_addr_idx;

    // An address is usable only if word-aligned and below DEPTH*4; no aliasing.
    assign w_pc_ok    = (bus.Pc[31:AW+2] == '0)         && (bus.Pc[1:0] == 2'b00);
    assign w_ld_ok    = (bus.ImLoadAddr[31:AW+2] == '0) && (bus.ImLoadAddr[1:0] == 2'b00);
    assign w_addr_ok  = (bus.Address[31:AW+2] == '0)    && (bus.Address[1:0] == 2'b00);
    assign w_pc_idx   = bus.Pc[AW+1:2];
    assign w_ld_idx   = bus.ImLoadAddr[AW+1:2];
    assign w_addr_idx = bus.Address[AW+1:2];

    // NOTE: both arrays are cleared by reset, so they build as flops, not RAM macros.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_imem[i] <= '0;
            end
        end else if (bus.ImLoadEn && w_ld_ok) begin
            r_imem[w_ld_idx] <= bus.ImLoadData;
        end
    end

    // NOTE: non-blocking update means a same-edge load is not seen by this fetch.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_inst <= '0;
        end else begin
            r_inst <= w_pc_ok ? r_imem[w_pc_idx] : '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dmem[i] <= '0;
            end
        end else if (bus.MemWrite && w_addr_ok) begin
            r_dmem[w_addr_idx] <= bus.WriteData;
        end
    end

    assign bus.InstReg  = r_inst;
    assign bus.ReadData = (bus.MemRead && w_addr_ok) ? r_dmem[w_addr_idx] : '0;
    assign bus.InstErr  = !w_pc_ok;
    assign bus.DataErr  = (bus.MemRead || bus.MemWrite) && !w_addr_ok;

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem: reset, program load/fetch, data load/store,
// error flags and boundary addresses, with hand-computed expectations.
module tb_mem_subsystem;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mem_subsystem_if #(.WIDTH(32)) u_if ();

    mem_subsystem #(.WIDTH(32), .DEPTH(1024), .AW(10)) u_dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dwrite(input logic [31:0] addr, input logic [31:0] data);
        u_if.Address   = addr;
        u_if.WriteData = data;
        u_if.MemWrite  = 1'b1;
        u_if.MemRead   = 1'b0;
        tick();
        u_if.MemWrite  = 1'b0;
    endtask

    task automatic dread(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        u_if.Address = addr;
        u_if.MemRead = 1'b1;
        settle();
        check(tag, u_if.ReadData, exp);
        u_if.MemRead = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst_n            = 1'b0;
        u_if.Pc          = '0;
        u_if.ImLoadEn    = 1'b0;
        u_if.ImLoadAddr  = '0;
        u_if.ImLoadData  = '0;
        u_if.Address     = '0;
        u_if.WriteData   = '0;
        u_if.MemRead     = 1'b0;
        u_if.MemWrite    = 1'b0;

        // Reset state
        #12;
        check("rst_instreg", u_if.InstReg, 32'h0);
        check("rst_readdata", u_if.ReadData, 32'h0);
        check("rst_dataerr", {31'b0, u_if.DataErr}, 32'h0);
        rst_n = 1'b1;

        // Reset then fetch
        u_if.Pc = 32'd0;
        tick();
        check("fetch0", u_if.InstReg, 32'h0);
        u_if.Pc = 32'd4;
        tick();
        check("fetch4_empty", u_if.InstReg, 32'h0);
        check("insterr_pc4", {31'b0, u_if.InstErr}, 32'h0);

        // Program load then fetch; fetch reflects it only after the next edge
        u_if.Pc         = 32'd0;
        u_if.ImLoadEn   = 1'b1;
        u_if.ImLoadAddr = 32'd4;
        u_if.ImLoadData = 32'h8C22_0008;
        tick();
        u_if.ImLoadEn = 1'b0;
        u_if.Pc       = 32'd4;
        settle();
        check("load_not_before", u_if.InstReg, 32'h0);
        tick();
        check("load_fetch4", u_if.InstReg, 32'h8C22_0008);

        // Load and fetch of the same word on one edge: old contents captured
        u_if.Pc         = 32'd8;
        u_if.ImLoadEn   = 1'b1;
        u_if.ImLoadAddr = 32'd8;
        u_if.ImLoadData = 32'h1234_5678;
        tick();
        check("rbw_old", u_if.InstReg, 32'h0);
        u_if.ImLoadEn = 1'b0;
        tick();
        check("rbw_new", u_if.InstReg, 32'h1234_5678);

        // Misaligned and out-of-range loads are dropped
        u_if.ImLoadEn   = 1'b1;
        u_if.ImLoadAddr = 32'd13;
        u_if.ImLoadData = 32'hAAAA_AAAA;
        tick();
        u_if.ImLoadAddr = 32'd4096;
        u_if.ImLoadData = 32'h5555_5555;
        tick();
        u_if.ImLoadEn = 1'b0;
        u_if.Pc       = 32'd12;
        tick();
        check("load_misaligned_dropped", u_if.InstReg, 32'h0);
        u_if.Pc = 32'd0;
        tick();
        check("load_oor_dropped", u_if.InstReg, 32'h0);

        // Last instruction word
        u_if.ImLoadEn   = 1'b1;
        u_if.ImLoadAddr = 32'd4092;
        u_if.ImLoadData = 32'h0BAD_C0DE;
        tick();
        u_if.ImLoadEn = 1'b0;
        u_if.Pc       = 32'd4092;
        settle();
        check("insterr_4092", {31'b0, u_if.InstErr}, 32'h0);
        tick();
        check("fetch_4092", u_if.InstReg, 32'h0BAD_C0DE);

        // Data write/read at 8
        dwrite(32'd8, 32'h0);
        dread("dread8_zero", 32'd8, 32'h0);
        dwrite(32'd8, 32'hDEAD_BEEF);
        dread("dread8_beef", 32'd8, 32'hDEAD_BEEF);
        settle();
        check("memread0_forces0", u_if.ReadData, 32'h0);

        // Simultaneous read/write
        dwrite(32'd8, 32'h1111_1111);
        u_if.Address   = 32'd8;
        u_if.WriteData = 32'h2222_2222;
        u_if.MemRead   = 1'b1;
        u_if.MemWrite  = 1'b1;
        settle();
        check("rw_before_edge", u_if.ReadData, 32'h1111_1111);
        tick();
        check("rw_after_edge", u_if.ReadData, 32'h2222_2222);
        u_if.MemWrite = 1'b0;
        u_if.MemRead  = 1'b0;

        // Out-of-range write flagged and dropped; word 0 unchanged
        dwrite(32'd0, 32'h1357_9BDF);
        u_if.Address   = 32'd4096;
        u_if.WriteData = 32'hFFFF_FFFF;
        u_if.MemWrite  = 1'b1;
        settle();
        check("dataerr_4096", {31'b0, u_if.DataErr}, 32'h1);
        tick();
        u_if.MemWrite = 1'b0;
        dread("word0_unchanged", 32'd0, 32'h1357_9BDF);

        // Misaligned read and write
        dwrite(32'd4, 32'h600D_CAFE);
        u_if.Address = 32'd6;
        u_if.MemRead = 1'b1;
        settle();
        check("dataerr_6", {31'b0, u_if.DataErr}, 32'h1);
        check("readdata_6", u_if.ReadData, 32'h0);
        u_if.MemRead = 1'b0;
        settle();
        check("dataerr_idle", {31'b0, u_if.DataErr}, 32'h0);
        dwrite(32'd6, 32'hFFFF_0000);
        dread("word1_unchanged", 32'd4, 32'h600D_CAFE);

        // Misaligned / out-of-range Pc
        u_if.Pc = 32'd2;
        settle();
        check("insterr_pc2", {31'b0, u_if.InstErr}, 32'h1);
        tick();
        check("instreg_pc2", u_if.InstReg, 32'h0);
        u_if.Pc = 32'd4096;
        settle();
        check("insterr_pc4096", {31'b0, u_if.InstErr}, 32'h1);

        // Last data word
        u_if.Address   = 32'd4092;
        u_if.WriteData = 32'hCAFE_F00D;
        u_if.MemWrite  = 1'b1;
        settle();
        check("dataerr_4092", {31'b0, u_if.DataErr}, 32'h0);
        tick();
        u_if.MemWrite = 1'b0;
        dread("dread_4092", 32'd4092, 32'hCAFE_F00D);

        // Reset mid-operation
        u_if.Pc = 32'd4;
        tick();
        check("pre_reset_instreg", u_if.InstReg, 32'h8C22_0008);
        rst_n = 1'b0;
        settle();
        check("async_rst_instreg", u_if.InstReg, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_fetch4", u_if.InstReg, 32'h0);
        dread("post_rst_dread8", 32'd8, 32'h0);
        dread("post_rst_dread4092", 32'd4092, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
